// File: rtl/imm_encoder.sv
// imm_encoder: packs register fields and an immediate into a RISC-V instruction word behind a single ready/valid output register.
module imm_encoder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] instr_out,
  output logic             err_out,
  input  logic             cnt_clr,
  output logic [7:0]       err_cnt,
  output logic [15:0]      instr_cnt
);
  logic signed [31:0] w_simm;
  logic               w_shift;
  logic               w_in5;
  logic               w_in12;
  logic               w_in20;
  logic               w_acc;
  logic [6:0]         w_iop;
  logic [31:0]        w_instr;
  logic               w_err;
  logic               r_valid;
  logic [31:0]        r_instr;
  logic               r_err;
  logic [7:0]         r_err_cnt;
  logic [15:0]        r_instr_cnt;
  assign w_simm   = imm;
  assign w_shift  = fmt == 3'd0 && (funct3 == 3'd1 || funct3 == 3'd5);
  assign w_in5    = w_simm >= -16 && w_simm <= 15;
  assign w_in12   = w_simm >= -2048 && w_simm <= 2047;
  assign w_in20   = w_simm >= -524288 && w_simm <= 524287;
  assign w_iop    = fmt == 3'd0 ? 7'b0010011 : fmt == 3'd1 ? 7'b0000011 : 7'b1100111;
  assign in_ready = !r_valid || out_ready;
  assign w_acc    = in_valid && in_ready;
  always_comb begin
    w_instr = 32'h0000_0013;
    w_err   = 1'b1;
    case (fmt)
      3'd0, 3'd1, 3'd5: begin
        w_instr = w_shift ? {funct7, imm[4:0], rs1, funct3, rd, w_iop} : {imm[11:0], rs1, funct3, rd, w_iop};
        w_err   = w_shift ? !w_in5 : !w_in12;
      end
      3'd2: begin
        w_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
        w_err   = !w_in12;
      end
      3'd3: begin
        w_instr = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], 7'b1100011};
        w_err   = funct3[2:1] == 2'b11 ? imm > 32'd4095 : !w_in12;
      end
      3'd4: begin
        w_instr = {imm[19], imm[9:0], imm[10], imm[18:11], rd, 7'b1101111};
        w_err   = !w_in20;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_instr <= w_instr;
      r_err   <= w_err;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (cnt_clr) begin
      r_instr_cnt <= {15'd0, w_acc};
      r_err_cnt   <= {7'd0, w_acc && w_err};
    end else if (w_acc) begin
      r_instr_cnt <= r_instr_cnt + 16'd1;
      r_err_cnt   <= w_err && r_err_cnt != 8'hFF ? r_err_cnt + 8'd1 : r_err_cnt;
    end
  end
  assign out_valid = r_valid;
  assign instr_out = r_instr;
  assign err_out   = r_err;
  assign err_cnt   = r_err_cnt;
  assign instr_cnt = r_instr_cnt;
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized and directed jobs scored against an arithmetic encoding model and an immGen decode.
module tb_imm_encoder;
  typedef struct {
    logic [2:0]  fmt;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic        err_out;
  logic        cnt_clr;
  logic [7:0]  err_cnt;
  logic [15:0] instr_cnt;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  exp_t cur;
  int m_i;
  int m_e;
  bit hold;
  logic [31:0] h_instr;
  logic h_err;
  bit rnd_ready = 0;
  int bnd[14] = '{-16, 15, 16, -17, -2048, 2047, 2048, -2049, 4095, 4096, -524288, 524287, 524288, -524289};
  imm_encoder #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out), .err_out(err_out),
    .cnt_clr(cnt_clr), .err_cnt(err_cnt), .instr_cnt(instr_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic exp_t ref_model(input logic [31:0] f, r_d, r_s1, r_s2, f3, f7, im);
    exp_t e;
    longint v, lo, hi;
    v = longint'($signed(im));
    e.fmt = f[2:0];
    e.f3 = f3[2:0];
    e.imm = im;
    lo = -2048;
    hi = 2047;
    case (f)
      0, 1, 5: begin
        if (f == 0 && (f3 == 1 || f3 == 5)) begin
          lo = -16;
          hi = 15;
          e.instr = f7 << 25 | (im & 31) << 20;
        end else e.instr = (im & 32'hFFF) << 20;
        e.instr = e.instr | r_s1 << 15 | f3 << 12 | r_d << 7 | (f == 0 ? 32'h13 : f == 1 ? 32'h03 : 32'h67);
      end
      2: e.instr = ((im >> 5) & 127) << 25 | r_s2 << 20 | r_s1 << 15 | f3 << 12 | (im & 31) << 7 | 32'h23;
      3: begin
        if (f3 >= 6) begin
          lo = 0;
          hi = 4095;
        end
        e.instr = ((im >> 11) & 1) << 31 | ((im >> 4) & 63) << 25 | r_s2 << 20 | r_s1 << 15 | f3 << 12
                | (im & 15) << 8 | ((im >> 10) & 1) << 7 | 32'h63;
      end
      4: begin
        lo = -524288;
        hi = 524287;
        e.instr = ((im >> 19) & 1) << 31 | (im & 1023) << 21 | ((im >> 10) & 1) << 20
                | ((im >> 11) & 255) << 12 | r_d << 7 | 32'h6F;
      end
      default: begin
        e.instr = 32'h13;
        lo = 1;
        hi = 0;
      end
    endcase
    e.err = v < lo || v > hi;
    return e;
  endfunction
  function automatic longint imm_gen(input exp_t e, input logic [31:0] x);
    logic signed [4:0] s5;
    logic signed [11:0] s12;
    logic signed [19:0] s20;
    logic [11:0] u12;
    case (e.fmt)
      3'd0, 3'd1, 3'd5: begin
        s5 = x[24:20];
        s12 = x[31:20];
        return (e.fmt == 0 && (e.f3 == 1 || e.f3 == 5)) ? longint'(s5) : longint'(s12);
      end
      3'd2: begin
        s12 = {x[31:25], x[11:7]};
        return longint'(s12);
      end
      3'd3: begin
        u12 = {x[31], x[7], x[30:25], x[11:8]};
        s12 = u12;
        return e.f3 >= 6 ? longint'(u12) : longint'(s12);
      end
      3'd4: begin
        s20 = {x[31], x[19:12], x[20], x[30:21]};
        return longint'(s20);
      end
      default: return 0;
    endcase
  endfunction
  task automatic setjob(input int f, input int r_d, input int r_s1, input int r_s2, input int f3, input int f7, input logic [31:0] im);
    fmt = 3'(f);
    rd = 5'(r_d);
    rs1 = 5'(r_s1);
    rs2 = 5'(r_s2);
    funct3 = 3'(f3);
    funct7 = 7'(f7);
    imm = im;
    cur = ref_model(32'(f), 32'(r_d), 32'(r_s1), 32'(r_s2), 32'(f3), 32'(f7), im);
  endtask
  task automatic setlit(input logic [31:0] instr, input logic err);
    cur.instr = instr;
    cur.err = err;
  endtask
  task automatic wait_accept();
    int n = 0;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(cur);
        break;
      end
      if (++n > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=%0d required=<200", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt_clr = 1'b0;
  endtask
  task automatic rand_job();
    logic [31:0] im;
    case ($urandom % 4)
      0: im = $urandom;
      1: im = 32'($urandom_range(0, 63)) - 32'd32;
      2: im = 32'(bnd[$urandom % 14]);
      default: im = 32'($urandom_range(0, 2097151)) - 32'd1048576;
    endcase
    setjob($urandom % 8, $urandom % 32, $urandom % 32, $urandom % 32, $urandom % 8, $urandom % 128, im);
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    bit acc;
    if (!rst_n) begin
      m_i = 0;
      m_e = 0;
      q.delete();
      hold = 0;
    end else begin
      chk("instr_cnt", 32'(instr_cnt), 32'(m_i));
      chk("err_cnt", 32'(err_cnt), 32'(m_e));
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_instr", instr_out, h_instr);
        chk("hold_err", 32'(err_out), 32'(h_err));
      end
      hold = out_valid && !out_ready;
      h_instr = instr_out;
      h_err = err_out;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", instr_out);
        end else begin
          e = q.pop_front();
          chk("instr_out", instr_out, e.instr);
          chk("err_out", 32'(err_out), 32'(e.err));
          if (!e.err) chk("immgen_roundtrip", 32'(imm_gen(e, instr_out)), e.imm);
        end
      end
      acc = in_valid && in_ready;
      if (cnt_clr) begin
        m_i = acc ? 1 : 0;
        m_e = (acc && cur.err) ? 1 : 0;
      end else if (acc) begin
        m_i = (m_i + 1) % 65536;
        if (cur.err && m_e < 255) m_e++;
      end
    end
  end
  initial begin
    fork
      forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom % 4) != 0;
      end
    join_none
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    setjob(0, 0, 0, 0, 0, 0, 32'd0);
    #12;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_instr_out", instr_out, 32'd0);
    chk("reset_err_out", 32'(err_out), 32'd0);
    chk("reset_instr_cnt", 32'(instr_cnt), 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    setjob(0, 1, 0, 0, 0, 0, 32'hFFFF_FFFF);
    setlit(32'hFFF0_0093, 1'b0);
    wait_accept();
    chk("first_job_valid", 32'(out_valid), 32'd1);
    chk("first_job_cnt", 32'(instr_cnt), 32'd1);
    setjob(4, 1, 0, 0, 0, 0, 32'd2);
    setlit(32'h0040_00EF, 1'b0);
    wait_accept();
    setjob(4, 1, 0, 0, 0, 0, 32'h0008_0000);
    setlit(32'h8000_00EF, 1'b1);
    wait_accept();
    setjob(3, 0, 0, 0, 7, 0, 32'd4095);
    setlit(32'hFE00_7FE3, 1'b0);
    wait_accept();
    setjob(3, 0, 0, 0, 0, 0, 32'd4095);
    setlit(32'hFE00_0FE3, 1'b1);
    wait_accept();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    setjob(2, 0, 3, 4, 2, 0, 32'hFFFF_F800);
    wait_accept();
    setjob(0, 5, 6, 0, 1, 32, 32'd7);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    repeat (256) begin
      setjob(6 + $urandom % 2, $urandom % 32, $urandom % 32, $urandom % 32, $urandom % 8, 0, $urandom);
      wait_accept();
    end
    @(negedge clk);
    chk("err_cnt_saturated", 32'(err_cnt), 32'd255);
    @(posedge clk);
    #1;
    setjob(7, 0, 0, 0, 0, 0, 32'd0);
    cnt_clr = 1'b1;
    wait_accept();
    @(negedge clk);
    chk("clr_err_cnt", 32'(err_cnt), 32'd1);
    chk("clr_instr_cnt", 32'(instr_cnt), 32'd1);
    @(posedge clk);
    #1;
    rnd_ready = 1;
    repeat (600) begin
      if ($urandom % 5 == 0) begin
        @(posedge clk);
        #1;
      end
      rand_job();
      cnt_clr = ($urandom % 40) == 0;
      wait_accept();
    end
    rnd_ready = 0;
    @(posedge clk);
    #1;
    drain();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rand_job();
    wait_accept();
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    chk("async_reset_instr", instr_out, 32'd0);
    chk("async_reset_instr_cnt", 32'(instr_cnt), 32'd0);
    chk("async_reset_err_cnt", 32'(err_cnt), 32'd0);
    chk("async_reset_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rereset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    setjob(0, 1, 0, 0, 0, 0, 32'hFFFF_FFFF);
    setlit(32'hFFF0_0093, 1'b0);
    wait_accept();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter WIDTH, default 32, instruction and immediate width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  request carries a valid encode job.
REQ-005 in_ready  output  1  block accepts a job this cycle.
REQ-006 fmt  input  3  format: 0 ITYPE, 1 LOADTYPE, 2 STYPE, 3 BTYPE, 4 JTYPE, 5 JALRTYPE, 6/7 invalid.
REQ-007 rd, rs1, rs2  input  5 each  register fields.
REQ-008 funct3  input  3  funct3 field.
REQ-009 funct7  input  7  placed in [31:25] for ITYPE shifts only.
REQ-010 imm  input  WIDTH  immediate, in the same units immGen produces; no implicit shifting.
REQ-011 out_valid  output  1  instr_out/err_out valid.
REQ-012 out_ready  input  1  consumer accepts output this cycle.
REQ-013 instr_out  output  WIDTH  encoded instruction.
REQ-014 err_out  output  1  immediate out of range or invalid fmt.
REQ-015 cnt_clr  input  1  synchronous clear of both counters.
REQ-016 err_cnt  output  8  saturating count of accepted jobs with error.
REQ-017 instr_cnt  output  16  wrapping count of accepted jobs.

Function
REQ-018 The block SHALL encode so that immGen(instr_out) == imm for every in-range job.
REQ-019 The opcode SHALL be 0010011, 0000011, 0100011, 1100011, 1101111, 1100111 for fmt 0-5; rd->[11:7], funct3->[14:12], rs1->[19:15], rs2->[24:20] where the format uses them.
REQ-020 ITYPE with funct3 1 or 5: imm range -16..15, imm[4:0]->[24:20], funct7->[31:25].
REQ-021 ITYPE other, LOADTYPE, JALRTYPE: range -2048..2047, imm[11:0]->[31:20].
REQ-022 STYPE: range -2048..2047, imm[11:5]->[31:25], imm[4:0]->[11:7].
REQ-023 BTYPE: imm[11]->[31], imm[10]->[7], imm[9:4]->[30:25], imm[3:0]->[11:8]; range 0..4095 if funct3 is 6 or 7, else -2048..2047.
REQ-024 JTYPE: range -524288..524287, imm[19]->[31], imm[18:11]->[19:12], imm[10]->[20], imm[9:0]->[30:21].
REQ-025 Out-of-range imm: fields carry truncated low bits and err_out=1.
REQ-026 Invalid fmt: instr_out=32'h00000013 and err_out=1.
REQ-027 One output register stage, latency 1 cycle: a job accepted at edge N is presented with out_valid=1 after edge N.
REQ-028 Acceptance occurs when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-029 When out_valid && !out_ready, instr_out and err_out SHALL hold stable.
REQ-030 When out_valid && out_ready && !in_valid, out_valid SHALL clear next cycle.
REQ-031 With simultaneous pop and accept, the new job SHALL replace the register with no bubble; full throughput is 1 job per cycle.
REQ-032 instr_cnt SHALL increment by 1 per accepted job and wrap from 65535 to 0.
REQ-033 err_cnt SHALL increment per accepted job with error and saturate at 255.
REQ-034 cnt_clr SHALL zero both counters; with a same-cycle accept, each counter SHALL load the value for that job alone (0 or 1).

Reset
REQ-035 While rst_n=0: out_valid=0, instr_out=0, err_out=0, err_cnt=0, instr_cnt=0.
REQ-036 Reset asserted mid-transaction SHALL discard the held job immediately, without waiting for a clock edge.
REQ-037 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-038 fmt=0, rd=1, rs1=0, funct3=0, imm=-1 -> next cycle instr_out=32'hFFF00093, err_out=0, instr_cnt=1.
REQ-039 fmt=4, rd=1, imm=2 -> 32'h004000EF; imm=32'h00080000 -> err_out=1, err_cnt increments.
REQ-040 fmt=3, rs1=rs2=0, funct3=7, imm=4095 -> 32'hFE007FE3, err_out=0; same job with funct3=0 -> err_out=1.
REQ-041 out_ready=0 for 3 cycles with two back-to-back jobs -> first job held stable, in_ready=0 for the second job; out_ready=1 -> both jobs delivered in order, no loss or duplication.
REQ-042 256 error jobs -> err_cnt=255; cnt_clr with a same-cycle error job -> err_cnt=1, instr_cnt=1.
REQ-043 rst_n pulsed low while out_valid=1 and out_ready=0 -> out_valid=0 immediately, all counters 0, in_ready=1 after release.
